// File: rtl/reg_file_seq.sv
`default_nettype none
// ============================================================================
// Module      : reg_file_seq
// Description : Instruction sequencer for the 4-entry x 4-bit register file.
//               Accepts one 8-bit instruction over valid/ready, sequences
//               register-file reads, executes LDI/ADD/SUB/MOV internally and
//               issues a single-cycle write-back with a done pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_file_seq #(
    parameter int DATA_W = 4,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        instr,
    input  logic              instr_valid,
    output logic              instr_ready,
    output logic [ADDR_W-1:0] sel_a,
    output logic [ADDR_W-1:0] sel_b,
    input  logic [DATA_W-1:0] out_a,
    input  logic [DATA_W-1:0] out_b,
    output logic              write_en,
    output logic [ADDR_W-1:0] sel_w,
    output logic [DATA_W-1:0] data_in,
    output logic              done,
    output logic              carry,
    output logic              zero
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_EXEC  = 2'd2,
        S_WRITE = 2'd3
    } state_t;

    localparam logic [1:0] c_OP_LDI = 2'b00;
    localparam logic [1:0] c_OP_ADD = 2'b01;
    localparam logic [1:0] c_OP_SUB = 2'b10;
    localparam logic [1:0] c_OP_MOV = 2'b11;

    state_t              r_state;
    logic [1:0]          r_op;
    logic [ADDR_W-1:0]   r_rd;
    logic                r_carry_cand;
    logic                r_instr_ready;
    logic [ADDR_W-1:0]   r_sel_a;
    logic [ADDR_W-1:0]   r_sel_b;
    logic                r_write_en;
    logic [ADDR_W-1:0]   r_sel_w;
    logic [DATA_W-1:0]   r_data_in;
    logic                r_done;
    logic                r_carry;
    logic                r_zero;

    logic [DATA_W:0]     w_sum;
    logic [DATA_W-1:0]   w_result;
    logic                w_carry_cand;

    assign w_sum = {1'b0, out_a} + {1'b0, out_b};

    // Execute datapath: operands come straight from the register-file read ports
    always_comb begin
        w_result     = out_a;
        w_carry_cand = 1'b0;
        case (r_op)
            c_OP_ADD: begin
                w_result     = w_sum[DATA_W-1:0];
                w_carry_cand = w_sum[DATA_W];
            end
            c_OP_SUB: begin
                w_result     = out_a - out_b;
                w_carry_cand = (out_a < out_b);
            end
            c_OP_MOV: begin
                w_result     = out_a;
                w_carry_cand = 1'b0;
            end
            default: begin
                w_result     = out_a;
                w_carry_cand = 1'b0;
            end
        endcase
    end

    // Sequencer FSM with registered register-file controls and flags
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_op          <= 2'b00;
            r_rd          <= '0;
            r_carry_cand  <= 1'b0;
            r_instr_ready <= 1'b1;
            r_sel_a       <= '0;
            r_sel_b       <= '0;
            r_write_en    <= 1'b0;
            r_sel_w       <= '0;
            r_data_in     <= '0;
            r_done        <= 1'b0;
            r_carry       <= 1'b0;
            r_zero        <= 1'b0;
        end else begin
            r_write_en <= 1'b0;
            r_done     <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (instr_valid) begin
                        r_op          <= instr[7:6];
                        r_rd          <= instr[5:4];
                        r_instr_ready <= 1'b0;
                        if (instr[7:6] == c_OP_LDI) begin
                            // LDI needs no operands: go straight to write-back
                            r_state    <= S_WRITE;
                            r_write_en <= 1'b1;
                            r_done     <= 1'b1;
                            r_sel_w    <= instr[5:4];
                            r_data_in  <= instr[3:0];
                        end else begin
                            r_state <= S_READ;
                            r_sel_a <= instr[3:2];
                            r_sel_b <= instr[1:0];
                        end
                    end
                end
                S_READ: begin
                    r_state <= S_EXEC;
                end
                S_EXEC: begin
                    // Capture the result so write-back data is stable for the whole WRITE cycle
                    r_data_in    <= w_result;
                    r_carry_cand <= w_carry_cand;
                    r_sel_w      <= r_rd;
                    r_write_en   <= 1'b1;
                    r_done       <= 1'b1;
                    r_state      <= S_WRITE;
                end
                S_WRITE: begin
                    r_zero <= (r_data_in == '0);
                    if ((r_op == c_OP_ADD) || (r_op == c_OP_SUB)) begin
                        r_carry <= r_carry_cand;
                    end
                    r_instr_ready <= 1'b1;
                    r_state       <= S_IDLE;
                end
                default: begin
                    r_instr_ready <= 1'b1;
                    r_state       <= S_IDLE;
                end
            endcase
        end
    end

    assign instr_ready = r_instr_ready;
    assign sel_a       = r_sel_a;
    assign sel_b       = r_sel_b;
    assign sel_w       = r_sel_w;
    assign data_in     = r_data_in;
    assign carry       = r_carry;
    assign zero        = r_zero;
    // Reset during WRITE must suppress the write landing on that same edge
    assign write_en    = r_write_en & ~rst;
    assign done        = r_done & ~rst;

endmodule
`default_nettype wire

// File: tb/tb_reg_file_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_file_seq
// Description : Self-checking bench for reg_file_seq with a behavioural
//               register file and an expected-write scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_file_seq;

    logic       clk;
    logic       rst;
    logic [7:0] instr;
    logic       instr_valid;
    logic       instr_ready;
    logic [1:0] sel_a;
    logic [1:0] sel_b;
    logic [3:0] out_a;
    logic [3:0] out_b;
    logic       write_en;
    logic [1:0] sel_w;
    logic [3:0] data_in;
    logic       done;
    logic       carry;
    logic       zero;

    int vectors;
    int fails;
    int wcount;

    typedef struct packed {
        logic [1:0] w;
        logic [3:0] d;
        logic       z;
        logic       c;
        logic [7:0] lat;
    } exp_t;

    exp_t       sb[$];
    logic [3:0] rf[4];
    logic [3:0] m_rf[4];
    logic       m_carry;
    logic       m_zero;

    reg_file_seq #(.DATA_W(4), .ADDR_W(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .sel_a       (sel_a),
        .sel_b       (sel_b),
        .out_a       (out_a),
        .out_b       (out_b),
        .write_en    (write_en),
        .sel_w       (sel_w),
        .data_in     (data_in),
        .done        (done),
        .carry       (carry),
        .zero        (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural register file: combinational reads, write on rising edge
    assign out_a = rf[sel_a];
    assign out_b = rf[sel_b];
    always @(posedge clk) begin
        if (write_en === 1'b1) begin
            rf[sel_w] <= data_in;
            wcount    <= wcount + 1;
        end
    end

    initial begin
        #300000;
        $display("FAIL timeout: observed no finish, expected finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Architectural model: computes the expected write-back and pushes it
    function automatic void expect_push(input logic [7:0] ins);
        logic [1:0] op;
        logic [3:0] a;
        logic [3:0] b;
        logic [4:0] s;
        exp_t       e;
        op = ins[7:6];
        a  = m_rf[ins[3:2]];
        b  = m_rf[ins[1:0]];
        e.w   = ins[5:4];
        e.lat = (op == 2'b00) ? 8'd1 : 8'd3;
        case (op)
            2'b00: e.d = ins[3:0];
            2'b01: begin s = {1'b0, a} + {1'b0, b}; e.d = s[3:0]; m_carry = s[4]; end
            2'b10: begin e.d = a - b; m_carry = (a < b); end
            default: e.d = a;
        endcase
        m_rf[ins[5:4]] = e.d;
        m_zero = (e.d == 4'd0);
        e.z = m_zero;
        e.c = m_carry;
        sb.push_back(e);
    endfunction

    // Checks one write-back against the head of the scoreboard
    task automatic check_write(input logic [7:0] n);
        exp_t e;
        if (sb.size() == 0) begin
            chk("sb_empty", 8'd1, 8'd0);
            return;
        end
        e = sb.pop_front();
        chk("latency", n, e.lat);
        chk("write_en", {7'd0, write_en}, 8'd1);
        chk("done", {7'd0, done}, 8'd1);
        chk("sel_w", {6'd0, sel_w}, {6'd0, e.w});
        chk("data_in", {4'd0, data_in}, {4'd0, e.d});
        @(negedge clk);
        chk("write_en_off", {7'd0, write_en}, 8'd0);
        chk("done_off", {7'd0, done}, 8'd0);
        chk("ready_back", {7'd0, instr_ready}, 8'd1);
        chk("zero", {7'd0, zero}, {7'd0, e.z});
        chk("carry", {7'd0, carry}, {7'd0, e.c});
        chk("rf_dest", {4'd0, rf[e.w]}, {4'd0, e.d});
    endtask

    // One full handshake: drive, follow READ/EXEC, check write-back
    task automatic send(input logic [7:0] ins);
        logic [7:0] n;
        n = 8'd0;
        while (instr_ready !== 1'b1 && n < 8'd20) begin
            @(negedge clk);
            n++;
        end
        chk("ready_idle", {7'd0, instr_ready}, 8'd1);
        expect_push(ins);
        instr       = ins;
        instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
        n = 8'd1;
        while (write_en !== 1'b1 && n < 8'd10) begin
            chk("busy", {7'd0, instr_ready}, 8'd0);
            chk("sel_a", {6'd0, sel_a}, {6'd0, ins[3:2]});
            chk("sel_b", {6'd0, sel_b}, {6'd0, ins[1:0]});
            @(negedge clk);
            n++;
        end
        check_write(n);
    endtask

    initial begin
        int wc0;
        vectors     = 0;
        fails       = 0;
        wcount      = 0;
        m_carry     = 1'b0;
        m_zero      = 1'b0;
        for (int i = 0; i < 4; i++) m_rf[i] = 4'd0;
        rst         = 1'b1;
        instr       = 8'h00;
        instr_valid = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_ready", {7'd0, instr_ready}, 8'd1);
        chk("rst_write_en", {7'd0, write_en}, 8'd0);
        chk("rst_done", {7'd0, done}, 8'd0);
        chk("rst_sels", {2'd0, sel_a, sel_b, sel_w}, 8'd0);
        chk("rst_data_in", {4'd0, data_in}, 8'd0);
        chk("rst_flags", {6'd0, carry, zero}, 8'd0);
        rst = 1'b0;
        @(negedge clk);

        // LDI r2,11
        send(8'b00_10_1011);

        // ADD with carry: 9 + 8 = 17 -> 1, carry
        send(8'b00_00_1001);
        send(8'b00_01_1000);
        send(8'b01_11_00_01);

        // SUB to zero, then SUB with borrow: 5 - 7 = 14
        send(8'b00_01_0101);
        send(8'b00_10_0101);
        send(8'b10_00_01_10);
        send(8'b00_11_0111);
        send(8'b10_00_01_11);

        // Valid held high across LDI r1,3 then ADD r1,r1,r1
        wc0 = wcount;
        expect_push(8'b00_01_0011);
        expect_push(8'b01_01_01_01);
        instr       = 8'b00_01_0011;
        instr_valid = 1'b1;
        @(negedge clk);
        check_write(8'd1);
        // WRITE of LDI has just retired; still in WRITE at previous negedge
        instr = 8'b01_01_01_01;
        chk("hold_idle_ready", {7'd0, instr_ready}, 8'd1);
        @(negedge clk);
        instr_valid = 1'b0;
        chk("hold_read_busy", {7'd0, instr_ready}, 8'd0);
        chk("hold_read_sel_a", {6'd0, sel_a}, 8'd1);
        @(negedge clk);
        chk("hold_exec_busy", {7'd0, instr_ready}, 8'd0);
        @(negedge clk);
        check_write(8'd3);
        repeat (4) @(negedge clk);
        chk("hold_write_count", wcount - wc0, 8'd2);
        chk("hold_r1", {4'd0, rf[1]}, 8'd6);

        // MOV preserves carry: 15 + 2 sets carry, then MOV r2,r0 with r0=0
        send(8'b00_00_1111);
        send(8'b00_01_0010);
        send(8'b01_11_00_01);
        send(8'b00_00_0000);
        send(8'b00_11_0101);
        send(8'b11_10_00_00);

        // Reset while in WRITE: ADD r2,r3,r3 must not land
        instr       = 8'b01_10_11_11;
        instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
        begin
            int n;
            n = 1;
            while (write_en !== 1'b1 && n < 10) begin
                @(negedge clk);
                n++;
            end
            chk("rstw_latency", n[7:0], 8'd3);
        end
        chk("rstw_pre_carry", {7'd0, carry}, 8'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rstw_write_en", {7'd0, write_en}, 8'd0);
        chk("rstw_ready", {7'd0, instr_ready}, 8'd1);
        chk("rstw_flags", {6'd0, carry, zero}, 8'd0);
        chk("rstw_r2", {4'd0, rf[2]}, 8'd0);
        chk("rstw_data_in", {4'd0, data_in}, 8'd0);
        m_carry = 1'b0;
        m_zero  = 1'b0;
        @(negedge clk);

        // Recovery after reset
        send(8'b00_10_0100);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/reg_file_seq.md
Name: reg_file_seq

Overview:
- Instruction sequencer that drives the 4-entry x 4-bit register file of the 4-bit CPU.
- Accepts one 8-bit instruction at a time over a valid/ready handshake.
- Sequences register-file reads, performs the 4-bit operation internally, then issues a single-cycle write-back.
- Sits between the fetch/decode stage and the register file; it is the only master of the register file's select, write-enable and data-in pins.

Parameters:
- DATA_W, 4, register data width; only 4 is supported.
- ADDR_W, 2, register select width; only 2 is supported.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- instr  input  8  instruction: op[7:6], rd[5:4], rs[3:2], rt[1:0]; for LDI, imm = instr[3:0].
- instr_valid  input  1  instr is valid this cycle.
- instr_ready  output  1  sequencer can accept an instruction.
- sel_a  output  2  register-file read port A select.
- sel_b  output  2  register-file read port B select.
- out_a  input  4  register-file read port A data (combinational).
- out_b  input  4  register-file read port B data (combinational).
- write_en  output  1  register-file write enable.
- sel_w  output  2  register-file write select.
- data_in  output  4  register-file write data.
- done  output  1  one-cycle pulse when write-back has been issued.
- carry  output  1  carry/borrow flag of the last ADD/SUB.
- zero  output  1  result == 0 flag of the last retired instruction.

Behaviour:
- Reset (rst=1 at a clk edge, from any state):
  - State goes to IDLE.
  - instr_ready=1 after reset; write_en=0, done=0.
  - sel_a, sel_b, sel_w, data_in = 0; carry=0, zero=0.
  - An instruction in flight is discarded and no write is issued.
- Opcodes:
  - 00 LDI: rd <= imm.
  - 01 ADD: rd <= rs + rt; carry = bit 4 of the 5-bit sum.
  - 10 SUB: rd <= rs - rt, mod 16; carry = 1 if rs < rt (borrow).
  - 11 MOV: rd <= rs; carry unchanged.
- FSM states: IDLE, READ, EXEC, WRITE.
- IDLE:
  - instr_ready=1.
  - On instr_valid=1, latch instr.
  - LDI: go to WRITE with result=imm.
  - Other ops: go to READ.
  - instr_valid=0: stay in IDLE.
- READ: instr_ready=0; sel_a=rs, sel_b=rt driven from the latched instruction. Next state is EXEC.
- EXEC:
  - sel_a/sel_b held.
  - At the end of the cycle, capture out_a/out_b, compute result and the carry candidate into registers.
  - Next state is WRITE.
- WRITE:
  - write_en=1, sel_w=rd, data_in=result for exactly one cycle; the register file updates at the end of this cycle.
  - done pulses high in the same cycle.
  - zero updates to (result==0) and carry updates per opcode, both at the end of the cycle.
  - Next state is IDLE.
- Outside WRITE, write_en=0 always; sel_w/data_in hold their last values.
- Latency, accept edge to write-back edge: LDI 1 cycle, others 3 cycles. Throughput is one instruction per 2 (LDI) or 4 cycles.
- instr_ready=1 only in IDLE.
- instr/instr_valid are ignored outside IDLE; the upstream stage must hold instr until the handshake completes.
- Back-to-back dependency is safe: the write in WRITE lands before the next READ samples. No bypass is needed.
- rs==rt and rd==rs/rt are all legal; operands come from the pre-write values.
- Arithmetic is 4-bit wrap-around, with no saturation.

Test Plan:
- Reset in WRITE: rst=1 while in WRITE -> next cycle write_en=0, instr_ready=1, carry=0, zero=0, and the target register is unchanged.
- LDI: instr=8'b00_10_1011 (LDI r2, 11) -> write_en=1, sel_w=2, data_in=11 one cycle after accept; done=1; zero=0.
- ADD with carry: r0=9, r1=8, ADD r3,r0,r1 -> sel_a=0, sel_b=1 in READ/EXEC; WRITE has data_in=1, sel_w=3; carry=1, zero=0; total 3 cycles after accept.
- SUB to zero: r1=5, r2=5, SUB r0,r1,r2 -> data_in=0, zero=1, carry=0. Then SUB r0,r1,r3 with r3=7 -> data_in=14, carry=1.
- Handshake and dependency:
  - Hold instr_valid=1 continuously with LDI r1,3 then ADD r1,r1,r1.
  - instr_ready deasserts outside IDLE; second instruction accepted only in IDLE.
  - Result r1=6; no instruction lost or duplicated.
- MOV preserves carry: set carry=1 via ADD, then MOV r2,r0 with r0=0 -> r2=0, zero=1, carry stays 1.
